// File: rtl/bin_to_bcd.sv
// Sequential double-dabble converter: 8-bit unsigned binary to 3-digit BCD in 8 shift cycles.
// Optional macro BIN_TO_BCD_START_EDGE_EN makes start rising-edge triggered instead of level.
module bin_to_bcd (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [7:0]  bin,
  output logic [11:0] bcd,
  output logic        busy,
  output logic        done
);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t      r_state;
  state_t      w_next;
  logic [19:0] r_work;
  logic [2:0]  r_cnt;
  logic [11:0] r_bcd;
  logic        w_trigger;
  logic        w_lastShift;
  logic [11:0] w_adj;
  logic [19:0] w_shifted;

`ifdef BIN_TO_BCD_START_EDGE_EN
  logic r_startPrev;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_startPrev <= 1'b0;
    else     r_startPrev <= start;
  end

  assign w_trigger = start & ~r_startPrev;
`else
  assign w_trigger = start;
`endif

  // r_work holds {hundreds, tens, ones, remaining binary bits}
  assign w_adj[11:8] = (r_work[19:16] >= 4'd5) ? r_work[19:16] + 4'd3 : r_work[19:16];
  assign w_adj[7:4]  = (r_work[15:12] >= 4'd5) ? r_work[15:12] + 4'd3 : r_work[15:12];
  assign w_adj[3:0]  = (r_work[11:8]  >= 4'd5) ? r_work[11:8]  + 4'd3 : r_work[11:8];
  assign w_shifted   = {w_adj, r_work[7:0]} << 1;
  assign w_lastShift = (r_cnt == 3'd7);
  assign bcd         = r_bcd;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    busy   = 1'b0;
    done   = 1'b0;
    case (r_state)
      IDLE:  if (w_trigger) w_next = SHIFT;
      SHIFT: begin
        busy = 1'b1;
        if (w_lastShift) w_next = DONE;
      end
      DONE: begin
        done   = 1'b1;
        w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  // The output register only changes on the final shift, so bcd holds the old result meanwhile.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_work <= 20'h00000;
      r_cnt  <= 3'd0;
      r_bcd  <= 12'h000;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_trigger) begin
            r_work <= {12'h000, bin};
            r_cnt  <= 3'd0;
          end
        end
        SHIFT: begin
          r_work <= w_shifted;
          r_cnt  <= r_cnt + 3'd1;
          if (w_lastShift) r_bcd <= w_shifted[19:8];
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_bin_to_bcd.sv
// Self-checking bench for bin_to_bcd: vector table with per-cycle latency checks,
// a done-driven scoreboard, and hand-written sequences for ignore/abort/hold cases.
module tb_bin_to_bcd;

  logic        clk;
  logic        rst;
  logic        start;
  logic [7:0]  bin;
  logic [11:0] bcd;
  logic        busy;
  logic        done;

  int checkCount = 0;
  int errorCount = 0;
  int doneCount  = 0;
  int cycleCnt   = 0;
  logic [11:0] prevBcd = 12'h000;
  logic [11:0] sb[$];
  int doneCycles[$];

  typedef struct {
    logic [7:0]  binIn;
    logic [11:0] expBcd;
  } vec_t;

  vec_t vecs[14];

  bin_to_bcd dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .bin   (bin),
    .bcd   (bcd),
    .busy  (busy),
    .done  (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cycleCnt++;

  task automatic checkOutput(input string name, input logic [11:0] act, input logic [11:0] exp);
    checkCount++;
    if (act !== exp) begin
      errorCount++;
      $display("[TB] FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask

  // Scoreboard: every done pulse pops one expected result and compares bcd.
  always @(negedge clk) begin
    if (!rst && done === 1'b1) begin
      doneCount++;
      doneCycles.push_back(cycleCnt);
      if (sb.size() == 0) begin
        checkCount++;
        errorCount++;
        $display("[TB] FAIL unexpected_done: got done with bcd %h, want no done", bcd);
      end else begin
        checkOutput("sb_bcd", bcd, sb.pop_front());
      end
    end
  end

  // One-cycle start pulse, then latency/busy/done/hold checks for the next 10 cycles.
  task automatic applyStimulus(input logic [7:0] v, input logic [11:0] exp);
    @(negedge clk);
    bin   = v;
    start = 1'b1;
    sb.push_back(exp);
    for (int cyc = 1; cyc <= 10; cyc++) begin
      @(negedge clk);
      if (cyc == 1) start = 1'b0;
      checkOutput($sformatf("busy_c%0d", cyc), {11'd0, busy}, {11'd0, (cyc <= 8)});
      checkOutput($sformatf("done_c%0d", cyc), {11'd0, done}, {11'd0, (cyc == 9)});
      checkOutput($sformatf("bcd_c%0d", cyc), bcd, (cyc <= 8) ? prevBcd : exp);
    end
    prevBcd = exp;
  endtask

  initial begin
    #50000;
    $display("[TB] FAIL watchdog: got timeout, want finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int d0;
    int expDones;

    vecs[0]  = '{8'd0,   12'h000};
    vecs[1]  = '{8'd255, 12'h255};
    vecs[2]  = '{8'd1,   12'h001};
    vecs[3]  = '{8'd5,   12'h005};
    vecs[4]  = '{8'd9,   12'h009};
    vecs[5]  = '{8'd10,  12'h010};
    vecs[6]  = '{8'd37,  12'h037};
    vecs[7]  = '{8'd99,  12'h099};
    vecs[8]  = '{8'd100, 12'h100};
    vecs[9]  = '{8'd128, 12'h128};
    vecs[10] = '{8'd199, 12'h199};
    vecs[11] = '{8'd200, 12'h200};
    vecs[12] = '{8'd250, 12'h250};
    vecs[13] = '{8'd64,  12'h064};

    rst   = 1'b1;
    start = 1'b0;
    bin   = 8'd0;
    #2;
    checkOutput("reset_bcd",  bcd, 12'h000);
    checkOutput("reset_busy", {11'd0, busy}, 12'h000);
    checkOutput("reset_done", {11'd0, done}, 12'h000);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    foreach (vecs[i]) applyStimulus(vecs[i].binIn, vecs[i].expBcd);

    // bin change and extra start during SHIFT must not affect the result.
    d0 = doneCount;
    @(negedge clk);
    bin   = 8'd100;
    start = 1'b1;
    sb.push_back(12'h100);
    for (int cyc = 1; cyc <= 14; cyc++) begin
      @(negedge clk);
      if (cyc == 1) start = 1'b0;
      if (cyc == 3) begin
        bin   = 8'd37;
        start = 1'b1;
      end
      if (cyc == 4) start = 1'b0;
    end
    checkOutput("ignore_done_count", 12'(doneCount - d0), 12'd1);
    checkOutput("ignore_bcd", bcd, 12'h100);
    prevBcd = 12'h100;

    // Reset at edge 4 of a conversion aborts it with no done pulse.
    applyStimulus(8'd99, 12'h099);
    d0 = doneCount;
    @(negedge clk);
    bin   = 8'd42;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    checkOutput("abort_bcd",  bcd, 12'h000);
    checkOutput("abort_busy", {11'd0, busy}, 12'h000);
    checkOutput("abort_done", {11'd0, done}, 12'h000);
    @(negedge clk);
    rst = 1'b0;
    for (int cyc = 0; cyc < 12; cyc++) @(negedge clk);
    checkOutput("abort_no_done", 12'(doneCount - d0), 12'd0);
    checkOutput("abort_idle_busy", {11'd0, busy}, 12'h000);
    prevBcd = 12'h000;
    applyStimulus(8'd42, 12'h042);

    // start held high for 25 cycles.
`ifdef BIN_TO_BCD_START_EDGE_EN
    expDones = 1;
`else
    expDones = 3;
`endif
    doneCycles.delete();
    @(negedge clk);
    bin   = 8'd225;
    start = 1'b1;
    for (int k = 0; k < expDones; k++) sb.push_back(12'h225);
    for (int cyc = 0; cyc < 25; cyc++) @(negedge clk);
    start = 1'b0;
    for (int cyc = 0; cyc < 15; cyc++) @(negedge clk);
    checkOutput("hold_done_count", 12'(doneCycles.size()), 12'(expDones));
    checkOutput("hold_bcd", bcd, 12'h225);
    if (doneCycles.size() >= 2)
      checkOutput("hold_spacing", 12'(doneCycles[1] - doneCycles[0]), 12'd10);
    if (doneCycles.size() >= 3)
      checkOutput("hold_spacing2", 12'(doneCycles[2] - doneCycles[1]), 12'd10);

    checkOutput("sb_empty", 12'(sb.size()), 12'd0);

    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule
